// File: rtl/button_pkg.sv
// Shared definitions for the multi-channel button front end.
//   btn_state_t : per-channel debounce/hold state
//   cnt_width() : width needed for a counter that reaches the largest of
//                 the debounce, long-press and repeat terminal values
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } btn_state_t;

   // Counter width covering max(a, b, c) inclusive
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, symmetric debouncer and the
// press / release / click / long-press / auto-repeat event generator.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   button        : raw asynchronous pin
//   pressed       : debounced level (1 while accepted as held)
//   *_pulse       : one-cycle registered event strobes
module button_channel
   import button_pkg::*;
#(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 100,
   parameter int LONG_CYCLES     = 1000,
   parameter int REPEAT_CYCLES   = 200
)(
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
   localparam logic INACTIVE = (ACTIVE_LOW != 0);
   localparam logic [W-1:0] ONE       = W'(1);
   localparam logic [W-1:0] DB_LAST   = W'(DEBOUNCE_CYCLES - 1);
   localparam logic [W-1:0] LONG_LAST = W'(LONG_CYCLES - 1);
   localparam logic [W-1:0] REP_LAST  = W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
   localparam logic [W-1:0] HOLD_MAX  = '1;

   logic sync1, sync2, act;
   btn_state_t state, state_nx;
   logic [W-1:0] db_cnt, db_nx, hold_cnt, hold_nx, hold_adv;
   logic long_seen, long_nx, seen_adv, long_adv, rep_adv;
   logic pressed_nx, press_nx, release_nx, click_nx, long_nx_p, repeat_nx;

   // Synchroniser idles at the inactive pin level so reset never looks
   // like a press; act is the polarity-normalised "button is down" sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= INACTIVE;
         sync2 <= INACTIVE;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
      end
   end

   assign act = sync2 ^ INACTIVE;

   // One held cycle worth of hold-counter progress. Used both in HELD and
   // when a release glitch is rejected, so the returning active sample
   // counts as held time and only the inactive samples are frozen.
   always_comb begin
      hold_adv = hold_cnt;
      seen_adv = long_seen;
      long_adv = 1'b0;
      rep_adv  = 1'b0;
      if (!long_seen) begin
         if (hold_cnt == LONG_LAST) begin
            hold_adv = '0;
            seen_adv = 1'b1;
            long_adv = 1'b1;
         end else begin
            hold_adv = hold_cnt + ONE;
         end
      end else if (REPEAT_CYCLES > 0) begin
         if (hold_cnt == REP_LAST) begin
            hold_adv = '0;
            rep_adv  = 1'b1;
         end else begin
            hold_adv = hold_cnt + ONE;
         end
      end else if (hold_cnt != HOLD_MAX) begin
         hold_adv = hold_cnt + ONE;
      end
   end

   // Next-state and event decode. A debounce length of one accepts a
   // change on the very first differing sample, skipping the wait states.
   always_comb begin
      state_nx   = state;
      db_nx      = db_cnt;
      hold_nx    = hold_cnt;
      long_nx    = long_seen;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      click_nx   = 1'b0;
      long_nx_p  = 1'b0;
      repeat_nx  = 1'b0;
      case (state)
         RELEASED: begin
            db_nx = '0;
            if (act) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nx = HELD;
                  press_nx = 1'b1;
                  hold_nx  = '0;
                  long_nx  = 1'b0;
               end else begin
                  state_nx = PRESS_WAIT;
                  db_nx    = ONE;
               end
            end
         end
         PRESS_WAIT: begin
            if (!act) begin
               state_nx = RELEASED;
               db_nx    = '0;
            end else if (db_cnt == DB_LAST) begin
               state_nx = HELD;
               press_nx = 1'b1;
               db_nx    = '0;
               hold_nx  = '0;
               long_nx  = 1'b0;
            end else begin
               db_nx = db_cnt + ONE;
            end
         end
         HELD: begin
            if (!act) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nx   = RELEASED;
                  release_nx = 1'b1;
                  click_nx   = !long_seen;
                  db_nx      = '0;
               end else begin
                  state_nx = RELEASE_WAIT;
                  db_nx    = ONE;
               end
            end else begin
               hold_nx   = hold_adv;
               long_nx   = seen_adv;
               long_nx_p = long_adv;
               repeat_nx = rep_adv;
            end
         end
         RELEASE_WAIT: begin
            if (act) begin
               state_nx  = HELD;
               db_nx     = '0;
               hold_nx   = hold_adv;
               long_nx   = seen_adv;
               long_nx_p = long_adv;
               repeat_nx = rep_adv;
            end else if (db_cnt == DB_LAST) begin
               state_nx   = RELEASED;
               release_nx = 1'b1;
               click_nx   = !long_seen;
               db_nx      = '0;
            end else begin
               db_nx = db_cnt + ONE;
            end
         end
         default: begin
            state_nx = RELEASED;
            db_nx    = '0;
         end
      endcase
      pressed_nx = (state_nx == HELD) || (state_nx == RELEASE_WAIT);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RELEASED;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         long_seen     <= 1'b0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         state         <= state_nx;
         db_cnt        <= db_nx;
         hold_cnt      <= hold_nx;
         long_seen     <= long_nx;
         pressed       <= pressed_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         click_pulse   <= click_nx;
         long_pulse    <= long_nx_p;
         repeat_pulse  <= repeat_nx;
      end
   end

endmodule

// File: rtl/button_events.sv
// Multi-channel debounced button front end. Instantiates one independent
// button_channel per pin and gathers their outputs into vectors.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   button        : raw asynchronous pins, one per channel
//   pressed       : debounced levels
//   *_pulse       : one-cycle event strobes, bit i belongs to channel i
module button_events #(
   parameter int CHANNELS        = 2,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 100,
   parameter int LONG_CYCLES     = 1000,
   parameter int REPEAT_CYCLES   = 200
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] pressed,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] click_pulse,
   output logic [CHANNELS-1:0] long_pulse,
   output logic [CHANNELS-1:0] repeat_pulse
);

   // Channels share nothing but the clock and reset
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      button_channel #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .button        (button[i]),
         .pressed       (pressed[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .click_pulse   (click_pulse[i]),
         .long_pulse    (long_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 5;

   logic       clk;
   logic       rst;
   logic [1:0] button;
   logic [1:0] pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;

   int testCount = 0;
   int failCount = 0;

   // Reference model: debounced level flips after D consecutive equal
   // synchronised samples; held time is the number of active samples seen
   // since acceptance.
   logic       mS1 [2];
   logic       mS2 [2];
   logic       runVal [2];
   int         runLen [2];
   logic       deb [2];
   int         heldCnt [2];
   logic       longFired [2];
   logic [1:0] expPressed, expPress, expRelease, expClick, expLong, expRepeat;

   button_events #(
      .CHANNELS        (2),
      .ACTIVE_LOW      (1),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .button        (button),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click_pulse   (click_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelReset();
      for (int ch = 0; ch < 2; ch++) begin
         mS1[ch]       = 1'b1;
         mS2[ch]       = 1'b1;
         runVal[ch]    = 1'b0;
         runLen[ch]    = 0;
         deb[ch]       = 1'b0;
         heldCnt[ch]   = 0;
         longFired[ch] = 1'b0;
      end
      expPressed = '0; expPress = '0; expRelease = '0;
      expClick = '0; expLong = '0; expRepeat = '0;
   endtask

   task automatic modelEdge(input logic [1:0] pins);
      logic act;
      expPress = '0; expRelease = '0; expClick = '0; expLong = '0; expRepeat = '0;
      for (int ch = 0; ch < 2; ch++) begin
         act     = ~mS2[ch];
         mS2[ch] = mS1[ch];
         mS1[ch] = pins[ch];
         if (runLen[ch] > 0 && act == runVal[ch]) runLen[ch]++;
         else begin
            runVal[ch] = act;
            runLen[ch] = 1;
         end
         if (!deb[ch] && runVal[ch] && runLen[ch] >= D) begin
            deb[ch]       = 1'b1;
            expPress[ch]  = 1'b1;
            heldCnt[ch]   = 0;
            longFired[ch] = 1'b0;
         end else if (deb[ch] && !runVal[ch] && runLen[ch] >= D) begin
            deb[ch]        = 1'b0;
            expRelease[ch] = 1'b1;
            expClick[ch]   = !longFired[ch];
         end else if (deb[ch] && act) begin
            heldCnt[ch]++;
            if (heldCnt[ch] == L) begin
               expLong[ch]   = 1'b1;
               longFired[ch] = 1'b1;
            end else if (heldCnt[ch] > L && ((heldCnt[ch] - L) % R) == 0) begin
               expRepeat[ch] = 1'b1;
            end
         end
         expPressed[ch] = deb[ch];
      end
   endtask

   task automatic checkVec(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkVec("pressed", pressed, expPressed);
      checkVec("press_pulse", press_pulse, expPress);
      checkVec("release_pulse", release_pulse, expRelease);
      checkVec("click_pulse", click_pulse, expClick);
      checkVec("long_pulse", long_pulse, expLong);
      checkVec("repeat_pulse", repeat_pulse, expRepeat);
   endtask

   task automatic checkZero();
      checkVec("rst_pressed", pressed, 2'b00);
      checkVec("rst_press", press_pulse, 2'b00);
      checkVec("rst_release", release_pulse, 2'b00);
      checkVec("rst_click", click_pulse, 2'b00);
      checkVec("rst_long", long_pulse, 2'b00);
      checkVec("rst_repeat", repeat_pulse, 2'b00);
   endtask

   // Drive pins just after an edge, take the next edge, then compare
   task automatic applyStimulus(input logic [1:0] pins);
      button = pins;
      @(posedge clk);
      modelEdge(pins);
      #1;
      checkOutput();
   endtask

   task automatic pulseReset();
      #2 rst = 1'b1;
      #1 checkZero();
      modelReset();
      #2 rst = 1'b0;
   endtask

   initial begin
      int longs, reps, clicks, rels, longStep, pressStep, sawAny;
      int remain [2];
      logic [1:0] level;

      rst    = 1'b1;
      button = 2'b11;
      #3 checkZero();
      modelReset();
      #5 rst = 1'b0;

      // Short press on channel 0: press after edge 5, release+click after edge 17
      for (int k = 0; k < 25; k++) begin
         applyStimulus({1'b1, (k < 12) ? 1'b0 : 1'b1});
         if (k == 5) checkVec("s1_press", press_pulse, 2'b01);
         if (k == 17) begin
            checkVec("s1_release", release_pulse, 2'b01);
            checkVec("s1_click", click_pulse, 2'b01);
         end
      end

      // Bouncing contact never accepted
      sawAny = 0;
      for (int r = 0; r < 10; r++)
         for (int j = 0; j < 4; j++) begin
            applyStimulus({1'b1, (j < 3) ? 1'b0 : 1'b1});
            if (pressed[0] || press_pulse[0]) sawAny = 1;
         end
      checkInt("s2_bounce_accepted", sawAny, 0);
      for (int k = 0; k < 6; k++) applyStimulus(2'b11);

      // Long hold: one long, five repeats, release without click
      longs = 0; reps = 0; clicks = 0; rels = 0;
      for (int k = 0; k < 58; k++) begin
         applyStimulus({1'b1, (k < 50) ? 1'b0 : 1'b1});
         longs  += int'(long_pulse[0]);
         reps   += int'(repeat_pulse[0]);
         clicks += int'(click_pulse[0]);
         rels   += int'(release_pulse[0]);
      end
      checkInt("s3_long_count", longs, 1);
      checkInt("s3_repeat_count", reps, 5);
      checkInt("s3_click_count", clicks, 0);
      checkInt("s3_release_count", rels, 1);
      for (int k = 0; k < 4; k++) applyStimulus(2'b11);

      // Release glitch during hold delays long press by two cycles
      longStep = -1; rels = 0;
      for (int k = 0; k < 38; k++) begin
         applyStimulus({1'b1, (k == 15 || k == 16 || k >= 30) ? 1'b1 : 1'b0});
         if (long_pulse[0] && longStep < 0) longStep = k;
         if (k < 34) rels += int'(release_pulse[0]);
      end
      checkInt("s4_long_step", longStep, 27);
      checkInt("s4_glitch_release", rels, 0);
      for (int k = 0; k < 4; k++) applyStimulus(2'b11);

      // Reset while channel 1 is held, then a fresh press
      for (int k = 0; k < 10; k++) applyStimulus(2'b01);
      pulseReset();
      pressStep = -1;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b01);
         if (press_pulse[1] && pressStep < 0) pressStep = k + 1;
      end
      checkInt("s5_press_after_reset", pressStep, 6);
      for (int k = 0; k < 8; k++) applyStimulus(2'b11);

      // Both channels pressed together
      for (int k = 0; k < 30; k++) applyStimulus(2'b00);
      for (int k = 0; k < 10; k++) applyStimulus(2'b11);

      // Randomised independent run lengths on both pins
      level  = 2'b11;
      remain[0] = 0;
      remain[1] = 0;
      for (int k = 0; k < 600; k++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (remain[ch] == 0) begin
               level[ch]  = ~level[ch];
               remain[ch] = level[ch] ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 50));
            end
            remain[ch]--;
         end
         applyStimulus(level);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
